dmem_port_arbiter: RTL and testbench

// - Shares the single data RAM between the CPU execute/memory stage and a host/debug port.
// - Sits between the CPU EM stage and the RAM: CPU path stays combinational; the host is served via a req/gnt handshake.
// - The CPU has priority. A starvation counter and a host burst lock bound host wait and CPU stall.

---
 rtl/cpu10_pkg.sv | 7 +
 rtl/arb_sat_counter.sv | 16 +
 rtl/dmem_port_arbiter.sv | 77 +++++++
 tb/tb_dmem_port_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu10_pkg.sv
// cpu10_pkg: shared data-path widths and data-memory arbiter encodings
package cpu10_pkg;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 10;
  typedef enum logic {S_CPU, S_HOST} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;
endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: up-counter that saturates at MAX; clr has priority over inc
module arb_sat_counter #(
  parameter int W = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != W'(MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: CPU-priority sharing of the data RAM with a host port, bounded by starvation and burst limits.
// Define ARB_STATS_EN to build the stall/grant statistic counters.
module dmem_port_arbiter #(
  parameter int DATA_W = cpu10_pkg::DATA_W,
  parameter int ADDR_W = cpu10_pkg::ADDR_W,
  parameter int MAX_WAIT = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_lock,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_cpu_stalls,
  output logic [15:0]       stat_host_grants
);
  import cpu10_pkg::*;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  arb_state_t state;
  owner_t own;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  assign host_gnt = host_req && (state == S_HOST ? host_lock && burst_cnt < BW'(BURST_MAX)
                                                 : !cpu_req || wait_cnt == WW'(MAX_WAIT));
  assign own = host_gnt ? OWN_HOST : cpu_req ? OWN_CPU : OWN_NONE;
  // A stall is only charged to the CPU when the host actually takes the RAM, so a burst exit slot goes to the CPU.
  assign cpu_stall = cpu_req && host_gnt;
  assign cpu_rdata = own == OWN_CPU ? mem_rdata : '0;
  assign mem_we = own == OWN_HOST ? host_we : own == OWN_CPU && cpu_we;
  assign mem_addr = own == OWN_HOST ? host_addr : own == OWN_CPU ? cpu_addr : '0;
  assign mem_wdata = own == OWN_HOST ? host_wdata : own == OWN_CPU ? cpu_wdata : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_CPU;
      host_rvalid <= 1'b0;
      host_rdata <= '0;
    end else begin
      state <= host_gnt && host_lock ? S_HOST : S_CPU;
      host_rvalid <= host_gnt && !host_we;
      if (host_gnt && !host_we) host_rdata <= mem_rdata;
    end
  arb_sat_counter #(.W(WW), .MAX(MAX_WAIT)) u_wait (
    .clk(clk), .rst(rst), .inc(host_req && !host_gnt),
    .clr(host_gnt || !host_req || state == S_HOST), .cnt(wait_cnt)
  );
  // Counts locked beats; any cycle that is not a locked grant ends the burst.
  arb_sat_counter #(.W(BW), .MAX(BURST_MAX)) u_burst (
    .clk(clk), .rst(rst), .inc(host_gnt), .clr(!(host_gnt && host_lock)), .cnt(burst_cnt)
  );
`ifdef ARB_STATS_EN
  arb_sat_counter #(.W(16), .MAX(65535)) u_stat_stall (
    .clk(clk), .rst(rst), .inc(cpu_stall), .clr(1'b0), .cnt(stat_cpu_stalls)
  );
  arb_sat_counter #(.W(16), .MAX(65535)) u_stat_gnt (
    .clk(clk), .rst(rst), .inc(host_gnt), .clr(1'b0), .cnt(stat_host_grants)
  );
`else
  assign stat_cpu_stalls = '0;
  assign stat_host_grants = '0;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: vector table plus hand sequences; host read data checked through a scoreboard queue
module tb_dmem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req, cpu_we, host_req, host_lock, host_we, host_gnt, host_rvalid, cpu_stall, mem_we;
  logic [9:0] cpu_addr, cpu_wdata, cpu_rdata, host_addr, host_wdata, host_rdata;
  logic [9:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] stat_cpu_stalls, stat_host_grants;
  logic [9:0] ram [1024];
  bit loaded;
  logic [9:0] exp_q [$];
  int checks = 0, errors = 0;
`ifdef ARB_STATS_EN
  localparam logic [15:0] EXP_STAT = 16'd1;
`else
  localparam logic [15:0] EXP_STAT = 16'd0;
`endif
  typedef struct {
    logic [44:0] in;
    logic [32:0] exp;
  } vec_t;
  vec_t vecs [9];

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .host_req(host_req),
    .host_lock(host_lock), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_cpu_stalls(stat_cpu_stalls), .stat_host_grants(stat_host_grants)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= (i == 5) ? 10'h2A3 : 10'(i * 7 + 3);
      loaded <= 1'b1;
    end else if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (host_rvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL host_rvalid_unexpected: got rdata %h with nothing outstanding", host_rdata);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (host_rdata !== e) begin
            errors++;
            $display("FAIL host_rdata: got %h expected %h", host_rdata, e);
          end
        end
      end
      if (host_gnt && !host_we) exp_q.push_back(ram[host_addr]);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_lock, host_we, host_addr, host_wdata} = '0;
    // in: cpu_req,cpu_we,cpu_addr,cpu_wdata,host_req,host_lock,host_we,host_addr,host_wdata
    // exp: cpu_rdata,cpu_stall,host_gnt,mem_we,mem_addr,mem_wdata
    vecs[0] = '{{1'b0,1'b0,10'h000,10'h000,1'b0,1'b0,1'b0,10'h000,10'h000}, {10'h000,1'b0,1'b0,1'b0,10'h000,10'h000}};
    vecs[1] = '{{1'b1,1'b0,10'h005,10'h3FF,1'b0,1'b0,1'b0,10'h000,10'h000}, {10'h2A3,1'b0,1'b0,1'b0,10'h005,10'h3FF}};
    vecs[2] = '{{1'b0,1'b0,10'h000,10'h000,1'b1,1'b0,1'b1,10'h010,10'h155}, {10'h000,1'b0,1'b1,1'b1,10'h010,10'h155}};
    vecs[3] = '{{1'b0,1'b0,10'h000,10'h000,1'b1,1'b0,1'b0,10'h010,10'h000}, {10'h000,1'b0,1'b1,1'b0,10'h010,10'h000}};
    vecs[4] = '{{1'b1,1'b1,10'h020,10'h0AA,1'b0,1'b0,1'b0,10'h000,10'h000}, {10'h0E3,1'b0,1'b0,1'b1,10'h020,10'h0AA}};
    vecs[5] = '{{1'b1,1'b0,10'h020,10'h000,1'b0,1'b0,1'b0,10'h000,10'h000}, {10'h0AA,1'b0,1'b0,1'b0,10'h020,10'h000}};
    vecs[6] = '{{1'b1,1'b1,10'h030,10'h111,1'b1,1'b0,1'b1,10'h030,10'h222}, {10'h153,1'b0,1'b0,1'b1,10'h030,10'h111}};
    vecs[7] = '{{1'b0,1'b0,10'h000,10'h000,1'b1,1'b0,1'b1,10'h030,10'h222}, {10'h000,1'b0,1'b1,1'b1,10'h030,10'h222}};
    vecs[8] = '{{1'b1,1'b0,10'h030,10'h000,1'b0,1'b0,1'b0,10'h000,10'h000}, {10'h222,1'b0,1'b0,1'b0,10'h030,10'h000}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rvalid", host_rvalid, 0);
    chk("reset_rdata", host_rdata, 0);
    chk("reset_stats", {stat_cpu_stalls, stat_host_grants}, 0);
    chk("reset_comb_idle", {host_gnt, cpu_stall, mem_we, mem_addr}, 0);
    next();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      {cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_lock, host_we, host_addr, host_wdata} = vecs[i].in;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {cpu_rdata, cpu_stall, host_gnt, mem_we, mem_addr, mem_wdata}, 64'(vecs[i].exp));
      next();
    end
    // starvation: CPU holds the RAM, host forced in on the fifth cycle
    {cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_lock, host_we, host_addr, host_wdata} = '0;
    rst = 1'b1;
    @(negedge clk);
    next();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 10'h040; host_req = 1'b1; host_addr = 10'h050;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("starve_gnt_c%0d", c), host_gnt, c == 5);
      chk($sformatf("starve_stall_c%0d", c), cpu_stall, c == 5);
      chk($sformatf("starve_cpu_rdata_c%0d", c), cpu_rdata, c == 5 ? 10'h000 : 10'h1C3);
      next();
    end
    host_addr = 10'h051;
    @(negedge clk);
    chk("starve_wait_cleared", host_gnt, 0);
    chk("stat_cpu_stalls", stat_cpu_stalls, EXP_STAT);
    chk("stat_host_grants", stat_host_grants, EXP_STAT);
    next();
    host_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    next();
    // burst: 8 locked beats, one CPU slot, then the host resumes
    host_req = 1'b1; host_lock = 1'b1; cpu_addr = 10'h061;
    for (int b = 1; b <= 8; b++) begin
      cpu_req = b > 1; host_addr = 10'(10'h100 + b);
      @(negedge clk);
      chk($sformatf("burst_gnt_b%0d", b), host_gnt, 1);
      chk($sformatf("burst_stall_b%0d", b), cpu_stall, b > 1);
      next();
    end
    @(negedge clk);
    chk("burst_exit_gnt", host_gnt, 0);
    chk("burst_exit_stall", cpu_stall, 0);
    chk("burst_exit_cpu_rdata", cpu_rdata, 10'h2AA);
    next();
    cpu_req = 1'b0;
    for (int b = 9; b <= 10; b++) begin
      host_addr = 10'(10'h100 + b);
      @(negedge clk);
      chk($sformatf("burst_regnt_b%0d", b), host_gnt, 1);
      next();
    end
    host_req = 1'b0; host_lock = 1'b0;
    @(negedge clk);
    chk("burst_release_gnt", host_gnt, 0);
    next();
    // reset mid-burst after beat 3
    host_req = 1'b1; host_lock = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      cpu_req = b > 1; host_addr = 10'(10'h200 + b);
      @(negedge clk);
      chk($sformatf("rburst_gnt_b%0d", b), host_gnt, 1);
      next();
    end
    host_addr = 10'h204; cpu_req = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_gnt", host_gnt, 0);
    chk("rst_mid_rvalid", host_rvalid, 0);
    chk("rst_mid_stall", cpu_stall, 0);
    chk("rst_mid_cpu_rdata", cpu_rdata, 10'h2AA);
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", host_gnt, 0);
    chk("post_rst_stall", cpu_stall, 0);
    chk("post_rst_cpu_rdata", cpu_rdata, 10'h2AA);
    next();
    {cpu_req, host_req, host_lock} = '0;
    @(negedge clk);
    next();
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
